// File: rtl/solver_pio_pkg.sv
// Shared definitions for the solver PIO blocks: register offsets and STATUS/CONTROL bit positions.
package solver_pio_pkg;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_COUNT   = 2'd3
  } reg_addr_e;

  localparam int unsigned ST_EMPTY_BIT     = 8;
  localparam int unsigned ST_FULL_BIT      = 9;
  localparam int unsigned ST_OVF_BIT       = 10;
  localparam int unsigned ST_VALID_BIT     = 11;

  localparam int unsigned CTRL_ENABLE_BIT  = 0;
  localparam int unsigned CTRL_FLUSH_BIT   = 1;
  localparam int unsigned CTRL_OVF_CLR_BIT = 2;

endpackage

// File: rtl/solver_out_pio_if.sv
// Avalon-MM slave bus plus the outgoing valid/ready word stream of solver_out_pio.
interface solver_out_pio_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [1:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_data, out_valid
  );

  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_data, out_valid
  );
endinterface

// File: rtl/solver_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push to a full FIFO is ignored and flush wins over push.
module solver_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       push_data,
  input  logic                        pop,
  input  logic                        flush,
  output logic [DATA_WIDTH-1:0]       head_c,
  output logic                        full_c,
  output logic                        empty_c,
  output logic [$clog2(DEPTH):0]      level_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  push_ok_c;
  logic                  pop_ok_c;

  always_comb begin
    empty_c   = (wr_ptr == rd_ptr);
    full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    level_c   = wr_ptr - rd_ptr;
    head_c    = mem[rd_ptr[AW-1:0]];
    push_ok_c = push && !full_c && !flush;
    pop_ok_c  = pop && !empty_c && !flush;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (!reset && push_ok_c) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/solver_out_pio.sv
// Avalon-MM output PIO: CPU writes operand words into a FIFO that drains into a valid/ready stream.
module solver_out_pio
  import solver_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic            clk,
  input  logic            reset,
  solver_out_pio_if.slave bus
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic                  wr_c;
  logic                  data_wr_c;
  logic                  ctrl_wr_c;
  logic                  count_wr_c;
  logic                  flush_c;
  logic                  ovf_clr_c;
  logic                  ovf_set_c;
  logic                  xfer_c;
  logic                  load_c;

  logic                  fifo_full_c;
  logic                  fifo_empty_c;
  logic [LVL_W-1:0]      fifo_level_c;
  logic [DATA_WIDTH-1:0] fifo_head_c;

  logic                  enable_q;
  logic                  ovf_q;
  logic [31:0]           count_q;
  logic [DATA_WIDTH-1:0] last_word_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic [31:0]           readdata_q;
  logic [31:0]           status_c;
  logic [31:0]           rd_mux_c;

  // Bus decode and stream handshake
  always_comb begin
    wr_c       = bus.chipselect && !bus.write_n;
    data_wr_c  = wr_c && (reg_addr_e'(bus.address) == REG_DATA);
    ctrl_wr_c  = wr_c && (reg_addr_e'(bus.address) == REG_CONTROL);
    count_wr_c = wr_c && (reg_addr_e'(bus.address) == REG_COUNT);
    flush_c    = ctrl_wr_c && bus.writedata[CTRL_FLUSH_BIT];
    ovf_clr_c  = ctrl_wr_c && bus.writedata[CTRL_OVF_CLR_BIT];
    ovf_set_c  = data_wr_c && fifo_full_c;
    xfer_c     = out_valid_q && bus.out_ready;
    load_c     = enable_q && !fifo_empty_c && (!out_valid_q || xfer_c) && !flush_c;
  end

  solver_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (data_wr_c),
    .push_data (bus.writedata[DATA_WIDTH-1:0]),
    .pop       (load_c),
    .flush     (flush_c),
    .head_c    (fifo_head_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c),
    .level_c   (fifo_level_c)
  );

  // Output register: a held word survives enable dropping, only flush or transfer retires it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (flush_c) begin
      out_valid_q <= 1'b0;
    end else if (load_c) begin
      out_data_q  <= fifo_head_c;
      out_valid_q <= 1'b1;
    end else if (xfer_c) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q    <= 1'b0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      last_word_q <= '0;
    end else begin
      if (ctrl_wr_c) enable_q <= bus.writedata[CTRL_ENABLE_BIT];
      if (ovf_set_c)      ovf_q <= 1'b1;
      else if (ovf_clr_c) ovf_q <= 1'b0;
      if (count_wr_c)  count_q <= '0;
      else if (xfer_c) count_q <= count_q + 32'd1;
      if (xfer_c) last_word_q <= out_data_q;
    end
  end

  always_comb begin
    status_c                  = '0;
    status_c[CNT_WIDTH-1:0]   = CNT_WIDTH'(fifo_level_c);
    status_c[ST_EMPTY_BIT]    = fifo_empty_c;
    status_c[ST_FULL_BIT]     = fifo_full_c;
    status_c[ST_OVF_BIT]      = ovf_q;
    status_c[ST_VALID_BIT]    = out_valid_q;

    rd_mux_c = '0;
    case (reg_addr_e'(bus.address))
      REG_DATA:    rd_mux_c = 32'(last_word_q);
      REG_STATUS:  rd_mux_c = status_c;
      REG_CONTROL: rd_mux_c[CTRL_ENABLE_BIT] = enable_q;
      REG_COUNT:   rd_mux_c = count_q;
      default:     rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= rd_mux_c;
  end

  assign bus.readdata  = readdata_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule
